bkt_lvl_finder: RTL and testbench

Upstream stage of the bin-across backtrack engine: on a conflict, it walks the level-states RAM downward from the current decision level. It finds the highest level whose decision has not yet been flipped and marks that level as flipped. It clears the level entries above it, then hands the backtrack level and bin to the var-state backtrack stage via a start/done handshake. If no unflipped level exists, it reports UNSAT instead.

---
 rtl/bkt_lvl_finder_if.sv | 35 +++
 rtl/bkt_lvl_finder.sv | 173 +++++++++++++++++
 tb/tb_bkt_lvl_finder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bkt_lvl_finder_if.sv
// Handshake and level-states RAM port bundle for the backtrack level finder.
// slave = finder side, master = controller/RAM side.
interface bkt_lvl_finder_if #(
  parameter int WIDTH_LVL             = 16,
  parameter int WIDTH_BIN_ID          = 10,
  parameter int WIDTH_LVL_STATES      = 11,
  parameter int ADDR_WIDTH_LVL_STATES = 9
);
  logic                             start_i;
  logic [WIDTH_LVL-1:0]             cur_lvl_i;
  logic                             done_o;
  logic                             unsat_o;
  logic                             apply_o;
  logic [WIDTH_LVL-1:0]             bkt_lvl_o;
  logic [WIDTH_BIN_ID-1:0]          bkt_bin_o;
  logic                             start_bkt_o;
  logic                             done_bkt_i;
  logic [ADDR_WIDTH_LVL_STATES-1:0] ram_raddr_ls_o;
  logic [WIDTH_LVL_STATES-1:0]      ram_rdata_ls_i;
  logic                             ram_we_ls_o;
  logic [ADDR_WIDTH_LVL_STATES-1:0] ram_waddr_ls_o;
  logic [WIDTH_LVL_STATES-1:0]      ram_wdata_ls_o;

  modport slave (
    input  start_i, cur_lvl_i, done_bkt_i, ram_rdata_ls_i,
    output done_o, unsat_o, apply_o, bkt_lvl_o, bkt_bin_o, start_bkt_o,
           ram_raddr_ls_o, ram_we_ls_o, ram_waddr_ls_o, ram_wdata_ls_o
  );

  modport master (
    output start_i, cur_lvl_i, done_bkt_i, ram_rdata_ls_i,
    input  done_o, unsat_o, apply_o, bkt_lvl_o, bkt_bin_o, start_bkt_o,
           ram_raddr_ls_o, ram_we_ls_o, ram_waddr_ls_o, ram_wdata_ls_o
  );
endinterface

// File: rtl/bkt_lvl_finder.sv
// Backtrack level finder: scans level states downward from the conflict level,
// marks the first unflipped level, clears the levels above it, then starts the var-state backtrack.
//
// state   | meaning
// IDLE    | waiting for start_i
// RD      | issue read of level lvl_cnt
// WAIT    | RAM read latency
// CHK     | inspect has_bkt of level lvl_cnt
// MARK    | write {dcd_bin,1} to the found level
// CLR     | zero one level above the found level per cycle
// BKT     | pulse start_bkt_o
// WBKT    | wait for done_bkt_i
// DONE    | success completion
// UNSAT   | no unflipped level left
module bkt_lvl_finder #(
  parameter int WIDTH_LVL             = 16,
  parameter int WIDTH_BIN_ID          = 10,
  parameter int WIDTH_LVL_STATES      = 11,
  parameter int ADDR_WIDTH_LVL_STATES = 9
) (
  input logic             clk,
  input logic             rst,
  bkt_lvl_finder_if.slave bus
);
  localparam logic [WIDTH_LVL-1:0] LVL_ZERO = '0;
  localparam logic [WIDTH_LVL-1:0] LVL_ONE  = WIDTH_LVL'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_WAIT, S_CHK, S_MARK, S_CLR, S_BKT, S_WBKT, S_DONE, S_UNSAT
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH_LVL-1:0]             lvl_cnt, lvl_cnt_nxt;
  logic [WIDTH_LVL-1:0]             top_lvl, top_lvl_nxt;
  logic [WIDTH_LVL-1:0]             clr_cnt, clr_cnt_nxt;
  logic [WIDTH_LVL-1:0]             bkt_lvl_q, bkt_lvl_nxt;
  logic [WIDTH_BIN_ID-1:0]          bkt_bin_q, bkt_bin_nxt;
  logic [ADDR_WIDTH_LVL_STATES-1:0] raddr_q, raddr_nxt;
  logic [ADDR_WIDTH_LVL_STATES-1:0] waddr_q, waddr_nxt;
  logic [WIDTH_LVL_STATES-1:0]      wdata_q, wdata_nxt;
  logic                             we_q, we_nxt;
  logic                             done_q, done_nxt;
  logic                             unsat_q, unsat_nxt;
  logic                             apply_q, apply_nxt;
  logic                             start_bkt_q, start_bkt_nxt;

  logic                    has_bkt;
  logic [WIDTH_BIN_ID-1:0] dcd_bin;

  assign has_bkt = bus.ram_rdata_ls_i[0];
  assign dcd_bin = bus.ram_rdata_ls_i[WIDTH_LVL_STATES-1:1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      lvl_cnt     <= '0;
      top_lvl     <= '0;
      clr_cnt     <= '0;
      bkt_lvl_q   <= '0;
      bkt_bin_q   <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      unsat_q     <= 1'b0;
      apply_q     <= 1'b0;
      start_bkt_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      lvl_cnt     <= lvl_cnt_nxt;
      top_lvl     <= top_lvl_nxt;
      clr_cnt     <= clr_cnt_nxt;
      bkt_lvl_q   <= bkt_lvl_nxt;
      bkt_bin_q   <= bkt_bin_nxt;
      raddr_q     <= raddr_nxt;
      waddr_q     <= waddr_nxt;
      wdata_q     <= wdata_nxt;
      we_q        <= we_nxt;
      done_q      <= done_nxt;
      unsat_q     <= unsat_nxt;
      apply_q     <= apply_nxt;
      start_bkt_q <= start_bkt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    lvl_cnt_nxt   = lvl_cnt;
    top_lvl_nxt   = top_lvl;
    clr_cnt_nxt   = clr_cnt;
    bkt_lvl_nxt   = bkt_lvl_q;
    bkt_bin_nxt   = bkt_bin_q;
    raddr_nxt     = raddr_q;
    waddr_nxt     = '0;
    wdata_nxt     = '0;
    we_nxt        = 1'b0;
    done_nxt      = 1'b0;
    unsat_nxt     = unsat_q;
    start_bkt_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          lvl_cnt_nxt = bus.cur_lvl_i;
          top_lvl_nxt = bus.cur_lvl_i;
          unsat_nxt   = 1'b0;
          state_nxt   = (bus.cur_lvl_i == LVL_ZERO) ? S_UNSAT : S_RD;
        end
      end
      S_RD: begin
        raddr_nxt = lvl_cnt[ADDR_WIDTH_LVL_STATES-1:0];
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_CHK;
      S_CHK: begin
        if (!has_bkt) begin
          bkt_lvl_nxt = lvl_cnt;
          bkt_bin_nxt = dcd_bin;
          state_nxt   = S_MARK;
        end else if (lvl_cnt == LVL_ONE) begin
          // level 0 is never scanned, so running out at level 1 means UNSAT
          state_nxt = S_UNSAT;
        end else begin
          lvl_cnt_nxt = lvl_cnt - LVL_ONE;
          state_nxt   = S_RD;
        end
      end
      S_MARK: begin
        we_nxt      = 1'b1;
        waddr_nxt   = bkt_lvl_q[ADDR_WIDTH_LVL_STATES-1:0];
        wdata_nxt   = {bkt_bin_q, 1'b1};
        clr_cnt_nxt = bkt_lvl_q + LVL_ONE;
        state_nxt   = (bkt_lvl_q < top_lvl) ? S_CLR : S_BKT;
      end
      S_CLR: begin
        we_nxt    = 1'b1;
        waddr_nxt = clr_cnt[ADDR_WIDTH_LVL_STATES-1:0];
        if (clr_cnt == top_lvl) state_nxt = S_BKT;
        else                    clr_cnt_nxt = clr_cnt + LVL_ONE;
      end
      S_BKT: begin
        start_bkt_nxt = 1'b1;
        state_nxt     = S_WBKT;
      end
      S_WBKT: if (bus.done_bkt_i) state_nxt = S_DONE;
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_UNSAT: begin
        done_nxt  = 1'b1;
        unsat_nxt = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    apply_nxt = (state_nxt != S_IDLE);
  end

  assign bus.done_o         = done_q;
  assign bus.unsat_o        = unsat_q;
  assign bus.apply_o        = apply_q;
  assign bus.bkt_lvl_o      = bkt_lvl_q;
  assign bus.bkt_bin_o      = bkt_bin_q;
  assign bus.start_bkt_o    = start_bkt_q;
  assign bus.ram_raddr_ls_o = raddr_q;
  assign bus.ram_we_ls_o    = we_q;
  assign bus.ram_waddr_ls_o = waddr_q;
  assign bus.ram_wdata_ls_o = wdata_q;
endmodule

// File: tb/tb_bkt_lvl_finder.sv
// Directed bench for bkt_lvl_finder with a one-cycle synchronous level-states RAM model.
module tb_bkt_lvl_finder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bkt_lvl_finder_if ifc ();

  bkt_lvl_finder dut (.clk(clk), .rst(rst), .bus(ifc));

  logic [10:0] mem [512];
  logic        load_en;
  logic [8:0]  load_addr;
  logic [10:0] load_data;
  int          cyc = 0;
  int          nwr = 0;
  int          nbkt = 0;
  logic [8:0]  wr_addr [64];
  logic [10:0] wr_data [64];
  int          wr_cyc  [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ifc.ram_rdata_ls_i <= mem[ifc.ram_raddr_ls_o];
    if (ifc.start_bkt_o) nbkt <= nbkt + 1;
    if (load_en) mem[load_addr] <= load_data;
    else if (ifc.ram_we_ls_o) begin
      mem[ifc.ram_waddr_ls_o] <= ifc.ram_wdata_ls_o;
      wr_addr[nwr] <= ifc.ram_waddr_ls_o;
      wr_data[nwr] <= ifc.ram_wdata_ls_o;
      wr_cyc[nwr]  <= cyc;
      nwr <= nwr + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic poke(input logic [8:0] a, input logic [10:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] lvl);
    ifc.start_i = 1'b1; ifc.cur_lvl_i = lvl;
    tick();
    ifc.start_i = 1'b0;
  endtask

  task automatic wait_bkt(input int max, output int lat);
    lat = 1;
    while (!ifc.start_bkt_o && lat < max) begin tick(); lat++; end
  endtask

  task automatic wait_done(input int max, output int lat);
    lat = 1;
    while (!ifc.done_o && lat < max) begin tick(); lat++; end
  endtask

  // downstream reply d cycles after start_bkt_o, then check the done pulse
  task automatic finish_bkt(input string tag, input int d);
    tick();
    chk({tag, "_bkt_pulse"}, 32'(ifc.start_bkt_o), 0);
    repeat (d - 1) tick();
    ifc.done_bkt_i = 1'b1;
    tick();
    ifc.done_bkt_i = 1'b0;
    chk({tag, "_done_early"}, 32'(ifc.done_o), 0);
    tick();
    chk({tag, "_done"}, 32'(ifc.done_o), 1);
    chk({tag, "_unsat"}, 32'(ifc.unsat_o), 0);
    chk({tag, "_apply_fall"}, 32'(ifc.apply_o), 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(ifc.done_o), 0);
  endtask

  initial begin
    int lat, base, nb0, bad, w_at;
    rst = 1'b0;
    ifc.start_i = 1'b0; ifc.cur_lvl_i = '0; ifc.done_bkt_i = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) tick();
    chk("rst_apply", 32'(ifc.apply_o), 0);
    chk("rst_done", 32'(ifc.done_o), 0);
    chk("rst_unsat", 32'(ifc.unsat_o), 0);
    chk("rst_we", 32'(ifc.ram_we_ls_o), 0);
    chk("rst_bkt_lvl", 32'(ifc.bkt_lvl_o), 0);
    chk("rst_start_bkt", 32'(ifc.start_bkt_o), 0);
    rst = 1'b1;
    tick();

    // T1: level 5 unflipped, bin 7
    for (int l = 1; l <= 4; l++) poke(9'(l), 11'(l << 1));
    poke(9'd5, 11'd14);
    base = nwr;
    do_start(16'd5);
    wait_bkt(40, lat);
    chk("t1_lat", 32'(lat), 6);
    chk("t1_start_bkt", 32'(ifc.start_bkt_o), 1);
    chk("t1_bkt_lvl", 32'(ifc.bkt_lvl_o), 5);
    chk("t1_bkt_bin", 32'(ifc.bkt_bin_o), 7);
    chk("t1_raddr", 32'(ifc.ram_raddr_ls_o), 5);
    finish_bkt("t1", 3);
    chk("t1_nwr", 32'(nwr - base), 1);
    chk("t1_waddr", 32'(wr_addr[base]), 5);
    chk("t1_wdata", 32'(wr_data[base]), 15);

    // T2: levels 5,4 flipped, level 3 unflipped with bin 2
    poke(9'd5, 11'd15); poke(9'd4, 11'd13); poke(9'd3, 11'd4);
    base = nwr;
    do_start(16'd5);
    wait_bkt(60, lat);
    chk("t2_lat", 32'(lat), 14);
    chk("t2_bkt_lvl", 32'(ifc.bkt_lvl_o), 3);
    chk("t2_bkt_bin", 32'(ifc.bkt_bin_o), 2);
    finish_bkt("t2", 2);
    chk("t2_nwr", 32'(nwr - base), 3);
    chk("t2_w0_addr", 32'(wr_addr[base]), 3);
    chk("t2_w0_data", 32'(wr_data[base]), 5);
    chk("t2_w1_addr", 32'(wr_addr[base+1]), 4);
    chk("t2_w1_data", 32'(wr_data[base+1]), 0);
    chk("t2_w2_addr", 32'(wr_addr[base+2]), 5);
    chk("t2_w2_data", 32'(wr_data[base+2]), 0);
    chk("t2_w_consec1", 32'(wr_cyc[base+1] - wr_cyc[base]), 1);
    chk("t2_w_consec2", 32'(wr_cyc[base+2] - wr_cyc[base]), 2);

    // T3: levels 1..3 all flipped -> UNSAT
    poke(9'd1, 11'd3); poke(9'd2, 11'd5); poke(9'd3, 11'd5);
    base = nwr; nb0 = nbkt;
    do_start(16'd3);
    wait_done(40, lat);
    chk("t3_lat", 32'(lat), 11);
    chk("t3_done", 32'(ifc.done_o), 1);
    chk("t3_unsat", 32'(ifc.unsat_o), 1);
    chk("t3_nwr", 32'(nwr - base), 0);
    chk("t3_nbkt", 32'(nbkt - nb0), 0);
    chk("t3_bkt_lvl_held", 32'(ifc.bkt_lvl_o), 3);
    chk("t3_bkt_bin_held", 32'(ifc.bkt_bin_o), 2);
    tick();
    chk("t3_done_pulse", 32'(ifc.done_o), 0);
    chk("t3_unsat_held", 32'(ifc.unsat_o), 1);

    // T4: cur_lvl 0 -> immediate UNSAT, no read or write
    base = nwr;
    do_start(16'd0);
    wait_done(5, lat);
    chk("t4_lat", 32'(lat), 2);
    chk("t4_done", 32'(ifc.done_o), 1);
    chk("t4_unsat", 32'(ifc.unsat_o), 1);
    chk("t4_raddr", 32'(ifc.ram_raddr_ls_o), 1);
    chk("t4_nwr", 32'(nwr - base), 0);

    // T5: stall in WBKT while start_i is pulsed
    poke(9'd4, 11'd18);
    base = nwr;
    do_start(16'd4);
    chk("t5_unsat_clr", 32'(ifc.unsat_o), 0);
    wait_bkt(40, lat);
    chk("t5_lat", 32'(lat), 6);
    chk("t5_bkt_lvl", 32'(ifc.bkt_lvl_o), 4);
    chk("t5_bkt_bin", 32'(ifc.bkt_bin_o), 9);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ifc.start_i = i[0]; ifc.cur_lvl_i = 16'd2;
      tick();
      if (!ifc.apply_o || ifc.done_o || ifc.start_bkt_o) bad++;
    end
    ifc.start_i = 1'b0;
    chk("t5_stall_bad", 32'(bad), 0);
    chk("t5_bkt_lvl_stall", 32'(ifc.bkt_lvl_o), 4);
    finish_bkt("t5", 1);
    chk("t5_nwr", 32'(nwr - base), 1);
    chk("t5_wdata", 32'(wr_data[base]), 19);
    tick();
    chk("t5_idle_apply", 32'(ifc.apply_o), 0);

    // T6: reset during CLR, then a fresh run
    poke(9'd9, 11'd6); poke(9'd10, 11'd1); poke(9'd11, 11'd1); poke(9'd12, 11'd1);
    base = nwr;
    do_start(16'd12);
    repeat (14) tick();
    chk("t6_we_in_clr", 32'(ifc.ram_we_ls_o), 1);
    rst = 1'b0;
    tick();
    chk("t6_rst_apply", 32'(ifc.apply_o), 0);
    chk("t6_rst_we", 32'(ifc.ram_we_ls_o), 0);
    chk("t6_rst_waddr", 32'(ifc.ram_waddr_ls_o), 0);
    chk("t6_rst_wdata", 32'(ifc.ram_wdata_ls_o), 0);
    chk("t6_rst_bkt_lvl", 32'(ifc.bkt_lvl_o), 0);
    chk("t6_rst_bkt_bin", 32'(ifc.bkt_bin_o), 0);
    chk("t6_rst_start_bkt", 32'(ifc.start_bkt_o), 0);
    chk("t6_rst_raddr", 32'(ifc.ram_raddr_ls_o), 0);
    w_at = nwr; nb0 = nbkt;
    repeat (4) tick();
    chk("t6_no_more_wr", 32'(nwr - w_at), 0);
    chk("t6_nwr_total", 32'(nwr - base), 2);
    chk("t6_no_bkt", 32'(nbkt - nb0), 0);
    rst = 1'b1;
    tick();
    base = nwr;
    do_start(16'd12);
    wait_bkt(60, lat);
    chk("t6_lat", 32'(lat), 14);
    chk("t6_bkt_lvl", 32'(ifc.bkt_lvl_o), 10);
    chk("t6_bkt_bin", 32'(ifc.bkt_bin_o), 0);
    finish_bkt("t6", 2);
    chk("t6_nwr", 32'(nwr - base), 3);
    chk("t6_w0", 32'({wr_addr[base], wr_data[base]}), 32'({9'd10, 11'd1}));
    chk("t6_w1", 32'({wr_addr[base+1], wr_data[base+1]}), 32'({9'd11, 11'd0}));
    chk("t6_w2", 32'({wr_addr[base+2], wr_data[base+2]}), 32'({9'd12, 11'd0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
